// File: rtl/nes_controller_responder_pkg.sv
// Shared constants, state encoding and frame-load helper for the NES/SNES pad responder.
// Build option: define SNES_MODE_EN for the 12-button, 16-bit SNES frame.
package nes_pkg;

  localparam int NES_FRAME_BITS  = 8;
  localparam int SNES_FRAME_BITS = 16;
  localparam logic DATA_RELEASED = 1'b1;

`ifdef SNES_MODE_EN
  localparam int BTN_W      = 12;
  localparam int FRAME_BITS = SNES_FRAME_BITS;
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;
`else
  localparam int BTN_W      = 8;
  localparam int FRAME_BITS = NES_FRAME_BITS;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LATCHED  = 2'd1,
    SHIFTING = 2'd2
  } state_t;

  // Buttons are active-high inside the chip but the wire is active-low; SNES pads
  // pad the frame with released bits (the standard controller ID).
  function automatic logic [FRAME_BITS-1:0] load_frame(input logic [BTN_W-1:0] btn);
`ifdef SNES_MODE_EN
    return {{(FRAME_BITS-BTN_W){DATA_RELEASED}}, ~btn};
`else
    return ~btn;
`endif
  endfunction

endpackage

// File: rtl/nes_controller_responder_strobe_synchronizer.sv
// Brings an asynchronous host strobe into the clk domain and reports its level and edges.
// Used twice by the responder, once for the latch and once for the host shift clock.
module strobe_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_history;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= '0;
      r_history <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_history <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_history;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_history;

endmodule

// File: rtl/nes_controller_responder.sv
// Device side of the NES controller link: answers host latch/clock polls with the button vector.
// Build option: define SNES_MODE_EN for the 12-button, 16-bit SNES frame.
module nes_controller_responder
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] buttons,
  input  logic             nes_latch,
  input  logic             nes_clk,
  output logic             nes_data,
  output logic             busy,
  output logic             frame_done,
  output logic [4:0]       bit_index
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [4:0]      LAST_BIT = 5'(FRAME_BITS - 1);

  logic w_latch_level, w_latch_rise, w_latch_fall;
  logic w_clk_rise;

  state_t                r_state, w_state_next;
  logic [FRAME_BITS-1:0] r_shift, w_shift_next;
  logic [4:0]            r_bit_index, w_bit_next;
  logic                  r_frame_done, w_done_next;
  logic [TO_W-1:0]       r_timeout, w_timeout_next;

  strobe_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (nes_latch),
    .o_level (w_latch_level),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  strobe_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (nes_clk),
    .o_level (),
    .o_rise  (w_clk_rise),
    .o_fall  ()
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '1;
      r_bit_index  <= '0;
      r_frame_done <= 1'b0;
      r_timeout    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bit_index  <= w_bit_next;
      r_frame_done <= w_done_next;
      r_timeout    <= w_timeout_next;
    end
  end

  // The latch always takes priority over a coincident host clock edge, so a
  // restart never also shifts.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_next     = r_bit_index;
    w_done_next    = 1'b0;
    w_timeout_next = '0;
    case (r_state)
      IDLE: begin
        if (w_latch_level) begin
          w_state_next = LATCHED;
          w_shift_next = load_frame(buttons);
          w_bit_next   = '0;
        end else if (w_clk_rise) begin
          w_shift_next = {DATA_RELEASED, r_shift[FRAME_BITS-1:1]};
        end
      end
      LATCHED: begin
        w_bit_next = '0;
        if (w_latch_fall) begin
          w_state_next = SHIFTING;
        end else begin
          w_shift_next = load_frame(buttons);
        end
      end
      SHIFTING: begin
        if (w_latch_rise) begin
          w_state_next = LATCHED;
          w_shift_next = load_frame(buttons);
          w_bit_next   = '0;
        end else if (w_clk_rise) begin
          w_shift_next = {DATA_RELEASED, r_shift[FRAME_BITS-1:1]};
          w_bit_next   = r_bit_index + 5'd1;
          if (r_bit_index == LAST_BIT) begin
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end
        end else if (r_timeout == TO_LIMIT) begin
          w_state_next = IDLE;
          w_shift_next = '1;
        end else begin
          w_timeout_next = r_timeout + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_shift_next = '1;
        w_bit_next   = '0;
      end
    endcase
  end

  assign nes_data   = r_shift[0];
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;
  assign bit_index  = r_bit_index;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Directed self-checking bench for nes_controller_responder (default NES build, or SNES_MODE_EN).
module tb_nes_controller_responder;
  import nes_pkg::*;

  localparam int TB_TIMEOUT = 64;
`ifdef SNES_MODE_EN
  localparam logic [15:0] SNES_EXPECT = 16'hF7FE;
`else
  localparam logic [7:0] NES_EXPECT = 8'b0111_1110;
`endif

  logic             clk;
  logic             reset;
  logic [BTN_W-1:0] buttons;
  logic             nes_latch;
  logic             nes_clk;
  logic             nes_data;
  logic             busy;
  logic             frame_done;
  logic [4:0]       bit_index;

  int vecCount  = 0;
  int missCount = 0;
  int doneCount = 0;

  nes_controller_responder #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .nes_latch  (nes_latch),
    .nes_clk    (nes_clk),
    .nes_data   (nes_data),
    .busy       (busy),
    .frame_done (frame_done),
    .bit_index  (bit_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) doneCount++;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doLatch(input logic [BTN_W-1:0] btn);
    buttons   = btn;
    nes_latch = 1'b1;
    cycles(12);
    nes_latch = 1'b0;
    cycles(6);
  endtask

  task automatic pulseClk();
    nes_clk = 1'b1;
    cycles(6);
    nes_clk = 1'b0;
    cycles(6);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    nes_latch = 1'b1;
    nes_clk   = 1'b0;
    buttons   = BTN_W'(1);
    cycles(2);
    reset = 1'b0;
    cycles(1);
    vecCount++;
    if (nes_data !== 1'b1) begin missCount++; $display("[TB] FAIL reset_data got=%b want=1", nes_data); end
    vecCount++;
    if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    vecCount++;
    if (bit_index !== 5'd0) begin missCount++; $display("[TB] FAIL reset_bit_index got=%0d want=0", bit_index); end
    cycles(1);
    vecCount++;
    if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy_early got=%b want=0", busy); end
    cycles(1);
    vecCount++;
    if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL reset_latched got=%b want=1", busy); end
    vecCount++;
    if (nes_data !== 1'b0) begin missCount++; $display("[TB] FAIL reset_latched_data got=%b want=0", nes_data); end
    nes_latch = 1'b0;
    cycles(6);
  endtask

`ifndef SNES_MODE_EN
  task automatic test_nes_frame();
    int d0;
    doLatch(8'b1000_0001);
    d0 = doneCount;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) buttons = 8'b0111_1110;
      vecCount++;
      if (nes_data !== NES_EXPECT[k]) begin
        missCount++;
        $display("[TB] FAIL nes_bit%0d got=%b want=%b", k, nes_data, NES_EXPECT[k]);
      end
      pulseClk();
    end
    vecCount++;
    if (doneCount !== d0 + 1) begin missCount++; $display("[TB] FAIL nes_frame_done got=%0d want=%0d", doneCount - d0, 1); end
    vecCount++;
    if (bit_index !== 5'd8) begin missCount++; $display("[TB] FAIL nes_bit_index got=%0d want=8", bit_index); end
    vecCount++;
    if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL nes_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_extra_clocks();
    int d0;
    d0 = doneCount;
    for (int k = 0; k < 2; k++) begin
      pulseClk();
      vecCount++;
      if (nes_data !== 1'b1) begin missCount++; $display("[TB] FAIL extra_data%0d got=%b want=1", k, nes_data); end
      vecCount++;
      if (bit_index !== 5'd8) begin missCount++; $display("[TB] FAIL extra_bit_index%0d got=%0d want=8", k, bit_index); end
    end
    vecCount++;
    if (doneCount !== d0) begin missCount++; $display("[TB] FAIL extra_frame_done got=%0d want=0", doneCount - d0); end
  endtask
`else
  task automatic test_snes_frame();
    int d0;
    doLatch(12'h801);
    d0 = doneCount;
    for (int k = 0; k < 16; k++) begin
      vecCount++;
      if (nes_data !== SNES_EXPECT[k]) begin
        missCount++;
        $display("[TB] FAIL snes_bit%0d got=%b want=%b", k, nes_data, SNES_EXPECT[k]);
      end
      pulseClk();
    end
    vecCount++;
    if (doneCount !== d0 + 1) begin missCount++; $display("[TB] FAIL snes_frame_done got=%0d want=1", doneCount - d0); end
    vecCount++;
    if (bit_index !== 5'd16) begin missCount++; $display("[TB] FAIL snes_bit_index got=%0d want=16", bit_index); end
    pulseClk();
    vecCount++;
    if (bit_index !== 5'd16) begin missCount++; $display("[TB] FAIL snes_saturate got=%0d want=16", bit_index); end
  endtask
`endif

  task automatic test_timeout();
    int d0;
    d0 = doneCount;
    doLatch(BTN_W'(0));
    for (int k = 0; k < 3; k++) pulseClk();
    vecCount++;
    if (bit_index !== 5'd3) begin missCount++; $display("[TB] FAIL timeout_bit_index got=%0d want=3", bit_index); end
    cycles(TB_TIMEOUT - 20);
    vecCount++;
    if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL timeout_early got=%b want=1", busy); end
    cycles(25);
    vecCount++;
    if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL timeout_busy got=%b want=0", busy); end
    vecCount++;
    if (nes_data !== 1'b1) begin missCount++; $display("[TB] FAIL timeout_data got=%b want=1", nes_data); end
    vecCount++;
    if (doneCount !== d0) begin missCount++; $display("[TB] FAIL timeout_frame_done got=%0d want=0", doneCount - d0); end
  endtask

  task automatic test_latch_collision();
    int d0;
    d0 = doneCount;
    doLatch(BTN_W'(2));
    for (int k = 0; k < 3; k++) pulseClk();
    buttons   = BTN_W'(1);
    nes_latch = 1'b1;
    nes_clk   = 1'b1;
    cycles(6);
    vecCount++;
    if (bit_index !== 5'd0) begin missCount++; $display("[TB] FAIL collide_bit_index got=%0d want=0", bit_index); end
    vecCount++;
    if (nes_data !== 1'b0) begin missCount++; $display("[TB] FAIL collide_data got=%b want=0", nes_data); end
    nes_clk = 1'b0;
    cycles(3);
    nes_latch = 1'b0;
    cycles(6);
    pulseClk();
    vecCount++;
    if (bit_index !== 5'd1) begin missCount++; $display("[TB] FAIL collide_restart got=%0d want=1", bit_index); end
    vecCount++;
    if (nes_data !== 1'b1) begin missCount++; $display("[TB] FAIL collide_next_data got=%b want=1", nes_data); end
    vecCount++;
    if (doneCount !== d0) begin missCount++; $display("[TB] FAIL collide_frame_done got=%0d want=0", doneCount - d0); end
  endtask

  task automatic test_midframe_reset();
    doLatch(BTN_W'(4));
    for (int k = 0; k < 2; k++) pulseClk();
    vecCount++;
    if (nes_data !== 1'b0) begin missCount++; $display("[TB] FAIL midreset_pre got=%b want=0", nes_data); end
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    vecCount++;
    if (nes_data !== 1'b1) begin missCount++; $display("[TB] FAIL midreset_data got=%b want=1", nes_data); end
    vecCount++;
    if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL midreset_busy got=%b want=0", busy); end
    vecCount++;
    if (bit_index !== 5'd0) begin missCount++; $display("[TB] FAIL midreset_bit_index got=%0d want=0", bit_index); end
  endtask

  initial begin
    test_reset();
`ifndef SNES_MODE_EN
    test_nes_frame();
    test_extra_clocks();
`else
    test_snes_frame();
`endif
    test_timeout();
    test_latch_collision();
    test_midframe_reset();
    cycles(4);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/nes_controller_responder.md
Name: nes_controller_responder

Overview:
- Device-side end of the NES serial controller link: emulates a standard NES pad.
- Presents a parallel, active-high button vector to a polling host over latch/clock/data.
- Used as the on-chip/bench counterpart to the game's controller poller, and for loopback testing of the NES pins.
- Samples host strobes in the system clock domain and drives an active-low serial data line.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on nes_latch and nes_clk before edge detection (minimum 2).
- TIMEOUT_CYCLES, 4096, system clocks without a host clock edge before SHIFTING abandons the frame. Counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- buttons  in  BTN_W  pressed=1; BTN_W=8 (12 with SNES_MODE_EN). Order [0]=B/A... see Behaviour.
- nes_latch  in  1  host latch strobe, asynchronous to clk.
- nes_clk  in  1  host shift clock, asynchronous to clk.
- nes_data  out  1  serial data, active-low (0 = pressed).
- busy  out  1  high in LATCHED or SHIFTING.
- frame_done  out  1  one-cycle pulse when the final button bit has been shifted out.
- bit_index  out  5  number of host clock edges accepted this frame, saturating at FRAME_BITS.

Behaviour:
- Bit order (NES): bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right. FRAME_BITS=8.
- Reset values: nes_data=1, busy=0, frame_done=0, bit_index=0, shift register all 1s, state IDLE, timeout counter 0.
- Sync path: each strobe passes SYNC_STAGES flops, then one history flop for edge detection.
  - Rising edge = synced & ~history.
  - Host edge to nes_data change latency = SYNC_STAGES+1 clk cycles (3 by default).
- States:
  - IDLE: nes_data = bit0 of the shift register. On synced latch high → LATCHED.
  - LATCHED: every cycle, shift_reg <= ~buttons (live reload); bit_index=0; nes_data=~buttons[0] registered. Latch falling → SHIFTING with the last loaded value frozen.
  - SHIFTING: on nes_clk rising edge, shift right, fill MSB with 1, bit_index++.
    - When bit_index reaches FRAME_BITS: assert frame_done for one cycle, then → IDLE.
    - Additional clk edges in IDLE keep shifting 1s, so nes_data=1 (released) and bit_index holds.
- Timeout: the counter runs only in SHIFTING and clears on every accepted edge. When it reaches TIMEOUT_CYCLES: → IDLE, no frame_done, shift register all 1s.
- Simultaneous events:
  - Latch high with a clk rising edge in the same cycle: latch wins, no shift.
  - Latch rising in any state: restart in LATCHED, bit_index=0, frame_done suppressed.
- Reset mid-frame: returns all outputs to reset values next cycle; the host sees nes_data=1.
- buttons changes during SHIFTING have no effect until the next latch.

Optional Feature:
- Macro: SNES_MODE_EN.
- Defined: BTN_W=12, FRAME_BITS=16.
  - Order: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R.
  - Bits 12-15 are driven 1 (standard pad ID); bit_index saturates at 16.
- Undefined: NES behaviour above; bit_index never exceeds 8.

Decomposition:
- Shared package nes_pkg:
  - button index constants (BTN_A…BTN_R)
  - NES_FRAME_BITS=8, SNES_FRAME_BITS=16
  - state encoding IDLE/LATCHED/SHIFTING (2-bit)
  - DATA_RELEASED=1'b1
- One sub-module: strobe_synchronizer (SYNC_STAGES flops + history flop; outputs level, rise, fall), instantiated for latch and clk.

Test Plan:
- Reset held 2 cycles with nes_latch=1 → nes_data=1, busy=0, bit_index=0 on the first cycle after release; LATCHED entered 3 cycles later.
- buttons=8'b1000_0001 (A, Right), latch pulse 12 cycles, then 8 clk pulses (6 high/6 low) → nes_data sequence 0,1,1,1,1,1,1,0; frame_done a single pulse after the 8th edge; bit_index=8.
- Ninth and tenth clk pulses after the frame → nes_data=1, bit_index stays 8, no second frame_done.
- Latch, 3 clk pulses, then idle for TIMEOUT_CYCLES+5 → returns to IDLE, busy=0, nes_data=1, no frame_done.
- Latch asserted in the same cycle as a clk rising edge mid-frame → bit_index=0 and nes_data=~buttons[0]; the shift is ignored.
- SNES_MODE_EN build, buttons=12'h801 (B, R) → 16 bits read 0,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1; frame_done after the 16th edge.
